// File: rtl/npu_agu_pkg.sv
// Shared definitions for the NPU fully-connected address generators (IAGU/WAGU).
package npu_agu_pkg;

    // Default datapath widths.
    localparam int AGU_ADDR_W  = 13;
    localparam int AGU_PIECE_W = 8;
    localparam int AGU_BATCH_W = 4;

    // Legal range of the accept-to-feature_end delay.
    localparam int AGU_END_DLY_MIN = 1;
    localparam int AGU_END_DLY_MAX = 4;
    localparam int AGU_END_DLY_DEF = 2;

    // Sequencer states, shared encoding with the WAGU FC successor.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_JUDGE  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } agu_state_e;

endpackage

// File: rtl/agu_pulse_delay.sv
// Fixed-depth pulse delay line: a pulse on pulse_in emerges DEPTH cycles later.
module agu_pulse_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic pulse_out
);

    logic [DEPTH-1:0] sr_r;

    // Shift the pulse through DEPTH stages; async clear drops pulses in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r <= '0;
        end else begin
            sr_r[0] <= pulse_in;
            for (int i = 1; i < DEPTH; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign pulse_out = sr_r[DEPTH-1];

endmodule

// File: rtl/iagu_fc_gen.sv
// FC feature-address generator: walks in/out/batch loops, issuing one
// feature-buffer read per weight group with backpressure and handshakes.
// END_DLY must lie in 1..4.
module iagu_fc_gen
    import npu_agu_pkg::*;
#(
    parameter int ADDR_W  = AGU_ADDR_W,
    parameter int PIECE_W = AGU_PIECE_W,
    parameter int BATCH_W = AGU_BATCH_W,
    parameter int END_DLY = AGU_END_DLY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_calculate,
    input  logic               weight_load_end,
    input  logic               rd_ready,
    input  logic [ADDR_W-1:0]  addr_start_d,
    input  logic [ADDR_W-1:0]  batch_stride,
    input  logic [PIECE_W-1:0] in_piece,
    input  logic [PIECE_W-1:0] out_piece,
    input  logic [BATCH_W-1:0] batch_num,
    output logic [ADDR_W-1:0]  o_d_addr,
    output logic               o_rd_en,
    output logic               o_feature_end,
    output logic               o_busy,
    output logic               o_done
);

    agu_state_e         state_r;
    agu_state_e         state_s;

    logic [ADDR_W-1:0]  base_r;
    logic [ADDR_W-1:0]  stride_r;
    logic [ADDR_W-1:0]  d_addr_r;
    logic [PIECE_W-1:0] in_last_r;
    logic [PIECE_W-1:0] out_last_r;
    logic [PIECE_W-1:0] in_idx_r;
    logic [PIECE_W-1:0] out_idx_r;
    logic [BATCH_W-1:0] batch_last_r;
    logic [BATCH_W-1:0] batch_idx_r;
    logic               sticky_r;
    logic               rd_en_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               in_wrap_s;
    logic               out_wrap_s;
    logic               batch_wrap_s;

    // Counts are stored as last index; a count of 0 behaves like 1.
    assign accept_s     = (state_r == ST_ISSUE) && rd_en_r && rd_ready;
    assign in_wrap_s    = (in_idx_r == in_last_r);
    assign out_wrap_s   = (out_idx_r == out_last_r);
    assign batch_wrap_s = (batch_idx_r == batch_last_r);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic for the per-group sequence ISSUE/JUDGE/UPDATE/WAIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_calculate) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    state_s = ST_JUDGE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_JUDGE: begin
                if (in_wrap_s && out_wrap_s && batch_wrap_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (weight_load_end || sticky_r) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Loop counters, incremental batch base, sticky handshake and read address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r       <= '0;
            stride_r     <= '0;
            d_addr_r     <= '0;
            in_last_r    <= '0;
            out_last_r   <= '0;
            in_idx_r     <= '0;
            out_idx_r    <= '0;
            batch_last_r <= '0;
            batch_idx_r  <= '0;
            sticky_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_calculate) begin
                        base_r       <= addr_start_d;
                        stride_r     <= batch_stride;
                        d_addr_r     <= addr_start_d;
                        in_last_r    <= (in_piece  == '0) ? '0 : in_piece  - PIECE_W'(1);
                        out_last_r   <= (out_piece == '0) ? '0 : out_piece - PIECE_W'(1);
                        batch_last_r <= (batch_num == '0) ? '0 : batch_num - BATCH_W'(1);
                        in_idx_r     <= '0;
                        out_idx_r    <= '0;
                        batch_idx_r  <= '0;
                        sticky_r     <= 1'b0;
                    end
                end
                ST_JUDGE: begin
                    if (weight_load_end) begin
                        sticky_r <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (weight_load_end) begin
                        sticky_r <= 1'b1;
                    end
                    if (!in_wrap_s) begin
                        in_idx_r <= in_idx_r + PIECE_W'(1);
                    end else begin
                        in_idx_r <= '0;
                        if (!out_wrap_s) begin
                            out_idx_r <= out_idx_r + PIECE_W'(1);
                        end else begin
                            out_idx_r   <= '0;
                            batch_idx_r <= batch_idx_r + BATCH_W'(1);
                            base_r      <= base_r + stride_r;
                        end
                    end
                end
                ST_WAIT: begin
                    if (weight_load_end || sticky_r) begin
                        sticky_r <= 1'b0;
                        d_addr_r <= base_r + ADDR_W'(in_idx_r);
                    end
                end
                default: begin
                    sticky_r <= sticky_r;
                end
            endcase
        end
    end

    // Registered status/request outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            rd_en_r <= (state_s == ST_ISSUE);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    agu_pulse_delay #(
        .DEPTH (END_DLY)
    ) u_feature_end_dly (
        .clk       (clk),
        .rst_n     (rst),
        .pulse_in  (accept_s),
        .pulse_out (o_feature_end)
    );

    assign o_d_addr = d_addr_r;
    assign o_rd_en  = rd_en_r;
    assign o_busy   = busy_r;
    assign o_done   = done_r;

endmodule

// File: tb/tb_iagu_fc_gen.sv
// Directed self-checking bench for iagu_fc_gen.
module tb_iagu_fc_gen;

    localparam int ADDR_W  = 13;
    localparam int PIECE_W = 8;
    localparam int BATCH_W = 4;
    localparam int END_DLY = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_calculate = 1'b0;
    logic               weight_load_end = 1'b0;
    logic               rd_ready = 1'b0;
    logic [ADDR_W-1:0]  addr_start_d = '0;
    logic [ADDR_W-1:0]  batch_stride = '0;
    logic [PIECE_W-1:0] in_piece = '0;
    logic [PIECE_W-1:0] out_piece = '0;
    logic [BATCH_W-1:0] batch_num = '0;
    logic [ADDR_W-1:0]  o_d_addr;
    logic               o_rd_en;
    logic               o_feature_end;
    logic               o_busy;
    logic               o_done;

    iagu_fc_gen #(
        .ADDR_W  (ADDR_W),
        .PIECE_W (PIECE_W),
        .BATCH_W (BATCH_W),
        .END_DLY (END_DLY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_calculate (start_calculate),
        .weight_load_end (weight_load_end),
        .rd_ready        (rd_ready),
        .addr_start_d    (addr_start_d),
        .batch_stride    (batch_stride),
        .in_piece        (in_piece),
        .out_piece       (out_piece),
        .batch_num       (batch_num),
        .o_d_addr        (o_d_addr),
        .o_rd_en         (o_rd_en),
        .o_feature_end   (o_feature_end),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Monitor records (written only by the monitor/responder processes).
    logic [ADDR_W-1:0] acc_addr_q[$];
    int acc_cyc_q[$];
    int fe_cyc_q[$];
    int done_cnt = 0;
    int wle_q[$];
    int wle_idx = 0;

    // Controls and snapshots (written only by the main sequence).
    bit resp_en = 1'b0;
    int wle_dly = 5;
    int acc_base, fe_base, done_base;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Observe accepts, feature_end pulses and done away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (o_rd_en && rd_ready) begin
                acc_addr_q.push_back(o_d_addr);
                acc_cyc_q.push_back(cyc);
                if (resp_en) wle_q.push_back(cyc + wle_dly);
            end
            if (o_feature_end) fe_cyc_q.push_back(cyc);
            if (o_done) done_cnt++;
        end
    end

    // Weight-side responder: pulse weight_load_end at each scheduled cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (wle_idx < wle_q.size() && wle_q[wle_idx] < cyc) wle_idx++;
            if (wle_idx < wle_q.size() && wle_q[wle_idx] == cyc) begin
                weight_load_end = 1'b1;
                wle_idx++;
            end else begin
                weight_load_end = 1'b0;
            end
        end
    end

    task automatic snap();
        acc_base  = acc_addr_q.size();
        fe_base   = fe_cyc_q.size();
        done_base = done_cnt;
    endtask

    task automatic start_layer(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                               input logic [PIECE_W-1:0] i, input logic [PIECE_W-1:0] o,
                               input logic [BATCH_W-1:0] b);
        @(posedge clk);
        #1;
        addr_start_d = a;
        batch_stride = s;
        in_piece = i;
        out_piece = o;
        batch_num = b;
        start_calculate = 1'b1;
        @(posedge clk);
        #1;
        start_calculate = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        check_eq({tag, "_done_count"}, done_cnt - done_base, 1);
        check_eq({tag, "_busy_after"}, {31'd0, o_busy}, 0);
    endtask

    task automatic verify(input string tag);
        int n_acc = acc_addr_q.size() - acc_base;
        int n_fe  = fe_cyc_q.size() - fe_base;
        check_eq({tag, "_reads"}, n_acc, exp_q.size());
        check_eq({tag, "_fe_count"}, n_fe, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_acc; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), {19'd0, acc_addr_q[acc_base+i]}, {19'd0, exp_q[i]});
            if (i < n_fe)
                check_eq($sformatf("%s_fe_lat%0d", tag, i), fe_cyc_q[fe_base+i] - acc_cyc_q[acc_base+i], END_DLY);
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {o_d_addr, o_rd_en, o_feature_end, o_busy, o_done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_ready = 1'b1;

        // Basic: 4x2 loop, handshake 2 cycles after WAIT entry.
        resp_en = 1'b1;
        wle_dly = 5;
        snap();
        start_layer(13'h100, 13'h000, 8'd4, 8'd2, 4'd1);
        wait_done("basic", 300);
        exp_q = '{13'h100, 13'h101, 13'h102, 13'h103, 13'h100, 13'h101, 13'h102, 13'h103};
        verify("basic");
        check_eq("basic_addr_hold", {19'd0, o_d_addr}, 32'h103);

        // Batch loop with stride.
        snap();
        start_layer(13'h010, 13'h020, 8'd2, 8'd1, 4'd3);
        wait_done("batch", 300);
        exp_q = '{13'h010, 13'h011, 13'h030, 13'h031, 13'h050, 13'h051};
        verify("batch");

        // Backpressure: hold rd_ready low for 5 ISSUE cycles.
        rd_ready = 1'b0;
        snap();
        start_layer(13'h055, 13'h000, 8'd1, 8'd1, 4'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_rd_en%0d", k), {31'd0, o_rd_en}, 1);
            check_eq($sformatf("bp_addr%0d", k), {19'd0, o_d_addr}, 32'h055);
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b1;
        wait_done("bp", 100);
        exp_q = '{13'h055};
        verify("bp");

        // Early handshake during JUDGE: groups spaced at the 4-cycle minimum.
        wle_dly = 1;
        snap();
        start_layer(13'h200, 13'h000, 8'd3, 8'd1, 4'd1);
        wait_done("early", 200);
        exp_q = '{13'h200, 13'h201, 13'h202};
        verify("early");
        if (acc_addr_q.size() - acc_base >= 3) begin
            check_eq("early_gap0", acc_cyc_q[acc_base+1] - acc_cyc_q[acc_base], 4);
            check_eq("early_gap1", acc_cyc_q[acc_base+2] - acc_cyc_q[acc_base+1], 4);
        end else begin
            check_eq("early_gap_reads", acc_addr_q.size() - acc_base, 3);
        end

        // Address wrap, zero out/batch counts treated as 1.
        wle_dly = 5;
        snap();
        start_layer(13'h1FFE, 13'h000, 8'd4, 8'd0, 4'd0);
        wait_done("wrap", 300);
        exp_q = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        verify("wrap");

        // Reset mid-run with a feature_end pulse in flight.
        resp_en = 1'b0;
        snap();
        start_layer(13'h300, 13'h000, 8'd4, 8'd1, 4'd1);
        begin
            int n = 0;
            while (acc_addr_q.size() == acc_base && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("mid_first_read", acc_addr_q.size() - acc_base, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {o_d_addr, o_rd_en, o_feature_end, o_busy, o_done}, 0);
        snap();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_no_fe", fe_cyc_q.size() - fe_base, 0);
        check_eq("mid_no_done", done_cnt - done_base, 0);
        check_eq("mid_idle", {o_busy, o_rd_en}, 0);

        // Fresh run after the aborted one.
        resp_en = 1'b1;
        snap();
        start_layer(13'h040, 13'h000, 8'd2, 8'd1, 4'd1);
        wait_done("post", 200);
        exp_q = '{13'h040, 13'h041};
        verify("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
